// File: rtl/sparc_pkg.sv
`default_nettype none
// ============================================================================
// Module : sparc_pkg
// Brief  : Shared SPARC integer-unit encodings: multiply FSM states, opcodes.
// Rev    : 1.0  initial release
// ============================================================================
package sparc_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mul_state_t;

    localparam logic [5:0] OP_UMUL   = 6'h0A;
    localparam logic [5:0] OP_SMUL   = 6'h0B;
    localparam logic [5:0] OP_UMULCC = 6'h1A;
    localparam logic [5:0] OP_SMULCC = 6'h1B;

endpackage
`default_nettype wire

// File: rtl/mul_step.sv
`default_nettype none
// ============================================================================
// Module : mul_step
// Brief  : One radix-2 shift-add iteration on the {acc, mag_b} product word.
// Rev    : 1.0  initial release
// ============================================================================
module mul_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] prod_in,
    input  logic [WIDTH-1:0]   mag_a,
    output logic [2*WIDTH-1:0] prod_out
);

    logic [WIDTH:0] sum;

    // The add carry becomes the new MSB as the whole word shifts right.
    always_comb begin
        sum      = {1'b0, prod_in[2*WIDTH-1:WIDTH]}
                 + (prod_in[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
        prod_out = {sum, prod_in[WIDTH-1:1]};
    end

endmodule
`default_nettype wire

// File: rtl/mul_seq.sv
`default_nettype none
// ============================================================================
// Module : mul_seq
// Brief  : Fixed-latency shift-add multiply sequencer (UMUL/SMUL[cc]).
//          Optional icc generation enabled by macro MUL_ICC_EN.
// Rev    : 1.0  initial release
// ============================================================================
module mul_seq
    import sparc_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic             set_cc,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] y_out,
    output logic             y_we,
    output logic             N,
    output logic             Z,
    output logic             V,
    output logic             C,
    output logic             icc_we
);

    localparam int CW = $clog2(WIDTH);

    mul_state_t         state, state_next;
    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   mag_a;
    logic [2*WIDTH-1:0] prod, prod_step;
    logic               neg;
    logic               accept;

    // busy still covers the done cycle, so a start there is ignored too.
    assign accept = (state == S_IDLE) && start && !busy;
    assign y_we   = done;

    mul_step #(.WIDTH(WIDTH)) u_step (
        .prod_in  (prod),
        .mag_a    (mag_a),
        .prod_out (prod_step)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_RUN;
            S_RUN:   if (count == CW'(WIDTH-1)) state_next = S_FIX;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy  <= 1'b0;
            done  <= 1'b0;
            res   <= '0;
            y_out <= '0;
            count <= '0;
            mag_a <= '0;
            prod  <= '0;
            neg   <= 1'b0;
        end else begin
            busy <= accept || (state != S_IDLE);
            done <= (state == S_DONE);
            case (state)
                S_IDLE: if (accept) begin
                    mag_a <= (is_signed && a[WIDTH-1]) ? -a : a;
                    prod  <= {{WIDTH{1'b0}}, ((is_signed && b[WIDTH-1]) ? -b : b)};
                    neg   <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                    count <= '0;
                end
                S_RUN: begin
                    prod  <= prod_step;
                    count <= count + 1'b1;
                end
                S_FIX:  if (neg) prod <= -prod;
                S_DONE: begin
                    res   <= prod[WIDTH-1:0];
                    y_out <= prod[2*WIDTH-1:WIDTH];
                end
                default: ;
            endcase
        end
    end

`ifdef MUL_ICC_EN
    logic cc_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cc_req <= 1'b0;
            icc_we <= 1'b0;
            N      <= 1'b0;
            Z      <= 1'b0;
        end else begin
            if (accept) cc_req <= set_cc;
            icc_we <= (state == S_DONE) && cc_req;
            if ((state == S_DONE) && cc_req) begin
                N <= prod[WIDTH-1];
                Z <= (prod[WIDTH-1:0] == '0);
            end
        end
    end

    assign V = 1'b0;
    assign C = 1'b0;
`else
    logic unused_set_cc;

    assign unused_set_cc = set_cc;
    assign icc_we = 1'b0;
    assign N      = 1'b0;
    assign Z      = 1'b0;
    assign V      = 1'b0;
    assign C      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mul_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_mul_seq
// Brief  : Self-checking bench for mul_seq against an arithmetic reference.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mul_seq;

    logic        clk = 1'b0;
    logic        reset, start, is_signed, set_cc;
    logic [31:0] a, b;
    logic        busy, done, y_we, n_f, z_f, v_f, c_f, icc_we;
    logic [31:0] res, y_out;

    int errors = 0;
    int checks = 0;

    logic exp_n, exp_z, exp_iw;

    mul_seq #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .set_cc(set_cc), .a(a), .b(b), .busy(busy), .done(done),
        .res(res), .y_out(y_out), .y_we(y_we),
        .N(n_f), .Z(z_f), .V(v_f), .C(c_f), .icc_we(icc_we)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y,
                                             input logic sgn);
        longint sx, sy;
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            return 64'(sx * sy);
        end
        return {32'd0, x} * {32'd0, y};
    endfunction

    // Expected condition codes: updated only by cc ops, held otherwise.
    task automatic model_cc(input logic [63:0] p, input logic cc);
`ifdef MUL_ICC_EN
        exp_iw = cc;
        if (cc) begin
            exp_n = p[31];
            exp_z = (p[31:0] == 32'd0);
        end
`else
        exp_iw = 1'b0;
        exp_n  = 1'b0;
        exp_z  = 1'b0;
`endif
    endtask

    // Issue one op and return at the negedge of the done cycle (lat = edges after E0).
    task automatic do_op(input logic [31:0] op_a, input logic [31:0] op_b,
                         input logic sgn, input logic cc, output int lat);
        @(negedge clk);
        a = op_a; b = op_b; is_signed = sgn; set_cc = cc; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; a = $urandom; b = $urandom;
        is_signed = 1'($urandom); set_cc = 1'($urandom);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; set_cc = 1'b0; a = '0; b = '0;
        exp_n = 1'b0; exp_z = 1'b0; exp_iw = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, y_we, icc_we, n_f, z_f, v_f, c_f} !== 8'h00 || res !== 0 || y_out !== 0) begin
            errors++;
            $display("FAIL reset_state: flags=%b res=%h y=%h required all zero",
                     {busy, done, y_we, icc_we, n_f, z_f, v_f, c_f}, res, y_out);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed;
        logic [31:0] ta [6] = '{32'd3, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h80000000, 32'd0, 32'h7FFFFFFF};
        logic [31:0] tb [6] = '{32'd5, 32'hFFFFFFFF, 32'd3, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
        logic        ts [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic        tc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [63:0] te [6] = '{64'h0000_0000_0000_000F, 64'hFFFF_FFFE_0000_0001,
                                64'hFFFF_FFFF_FFFF_FFFA, 64'h4000_0000_0000_0000,
                                64'h0, 64'hC000_0000_8000_0000};
        int lat;
        for (int i = 0; i < 6; i++) begin
            do_op(ta[i], tb[i], ts[i], tc[i], lat);
            model_cc(te[i], tc[i]);
            checks++;
            if (lat !== 34) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d required 34", i, lat);
            end
            checks++;
            if ({y_out, res} !== te[i]) begin
                errors++;
                $display("FAIL dir%0d_product: got %h_%h required %h", i, y_out, res, te[i]);
            end
            checks++;
            if ({y_we, icc_we, n_f, z_f, v_f, c_f} !== {1'b1, exp_iw, exp_n, exp_z, 2'b00}) begin
                errors++;
                $display("FAIL dir%0d_strobes: y_we/icc_we/NZVC=%b required %b", i,
                         {y_we, icc_we, n_f, z_f, v_f, c_f}, {1'b1, exp_iw, exp_n, exp_z, 2'b00});
            end
            @(negedge clk);
            checks++;
            if ({done, y_we, busy, icc_we} !== 4'b0000) begin
                errors++;
                $display("FAIL dir%0d_pulse: done/y_we/busy/icc_we=%b required 0000", i,
                         {done, y_we, busy, icc_we});
            end
        end
    endtask

    task automatic test_random;
        logic [31:0] ra, rb;
        logic        rs, rc;
        logic [63:0] p;
        int lat;
        for (int i = 0; i < 20; i++) begin
            ra = $urandom; rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = (i % 2) ? 32'h80000000 : 32'd0;
            if ($urandom_range(0, 3) == 0) rb = (i % 3 == 0) ? 32'hFFFFFFFF : 32'h80000000;
            rs = 1'($urandom); rc = 1'($urandom);
            p = ref_prod(ra, rb, rs);
            do_op(ra, rb, rs, rc, lat);
            model_cc(p, rc);
            checks++;
            if (lat !== 34 || {y_out, res} !== p) begin
                errors++;
                $display("FAIL rand%0d: %h*%h s=%b got lat=%0d %h_%h required lat=34 %h",
                         i, ra, rb, rs, lat, y_out, res, p);
            end
            checks++;
            if ({icc_we, n_f, z_f, v_f, c_f} !== {exp_iw, exp_n, exp_z, 2'b00}) begin
                errors++;
                $display("FAIL rand%0d_icc: icc_we/NZVC=%b required %b", i,
                         {icc_we, n_f, z_f, v_f, c_f}, {exp_iw, exp_n, exp_z, 2'b00});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_ignored;
        int ndone = 0;
        int first = -1;
        logic busy_mid = 1'b0;
        @(negedge clk);
        a = 32'd7; b = 32'd9; is_signed = 1'b0; set_cc = 1'b0; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 10) busy_mid = busy;
            if (done) begin
                ndone++;
                if (first < 0) first = n;
                model_cc(64'd63, 1'b0);
                checks++;
                if (res !== 32'h3F || y_out !== 32'h0 || icc_we !== 1'b0 ||
                    n_f !== exp_n || z_f !== exp_z) begin
                    errors++;
                    $display("FAIL ignore_result: res=%h y=%h icc_we=%b NZ=%b%b required 3f 0 0 %b%b",
                             res, y_out, icc_we, n_f, z_f, exp_n, exp_z);
                end
            end
            start = (n == 4 || n == 19);
            a = 32'hFFFF0000; b = 32'h0001FFFF; is_signed = 1'b1; set_cc = 1'b1;
        end
        start = 1'b0;
        checks++;
        if (ndone !== 1 || first !== 34 || busy_mid !== 1'b1) begin
            errors++;
            $display("FAIL ignore_start: dones=%0d first=%0d busy_mid=%b required 1 34 1",
                     ndone, first, busy_mid);
        end
    endtask

    task automatic test_reset_mid;
        int ndone = 0;
        int lat;
        @(negedge clk);
        a = 32'd5; b = 32'd6; is_signed = 1'b0; set_cc = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        exp_n = 1'b0; exp_z = 1'b0;
        #1;
        checks++;
        if ({busy, done, y_we, icc_we, n_f, z_f, v_f, c_f} !== 8'h00 || res !== 0 || y_out !== 0) begin
            errors++;
            $display("FAIL reset_mid: flags=%b res=%h y=%h required all zero",
                     {busy, done, y_we, icc_we, n_f, z_f, v_f, c_f}, res, y_out);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL reset_mid_nodone: active cycles=%0d required 0", ndone);
        end
        do_op(32'd2, 32'd2, 1'b0, 1'b0, lat);
        model_cc(64'd4, 1'b0);
        checks++;
        if (lat !== 34 || res !== 32'd4 || y_out !== 32'd0 || n_f !== exp_n || z_f !== exp_z) begin
            errors++;
            $display("FAIL after_reset_op: lat=%0d res=%h y=%h NZ=%b%b required 34 4 0 %b%b",
                     lat, res, y_out, n_f, z_f, exp_n, exp_z);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_start_ignored;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
